// File: rtl/complex_mul_seq_pkg.sv
// Shared types and constants for the time-multiplexed complex multiplier.
// The controller state type and the add/sub select encoding live here so the
// controller and the multiply-accumulate unit agree on them.
package complex_mul_seq_pkg;

  // One state per multiplier cycle, bracketed by the idle and result-hold states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MRR  = 3'd1,
    MII  = 3'd2,
    MIR  = 3'd3,
    MRI  = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic OP_SUM = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/cmul_mac_unit.sv
// Single WIDTH-bit multiplier feeding one add/sub stage with an accumulator.
// The product keeps only the low WIDTH bits and add/sub wraps modulo 2^WIDTH.
// result is combinational (acc op product) so the controller can capture it
// in the same cycle the operands are presented.
module cmul_mac_unit
  import complex_mul_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] mul_a,
  input  logic [WIDTH-1:0] mul_b,
  input  logic             op_sel,
  input  logic             acc_load,
  input  logic             acc_accum,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] product;
  logic [WIDTH-1:0] acc;

  // Low half of the product is identical for signed and unsigned operands
  always_comb begin
    product = mul_a * mul_b;
    if (op_sel == OP_SUB) begin
      result = acc - product;
    end else begin
      result = acc + product;
    end
  end

  // Accumulator either starts a new partial sum or folds in the current result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_load) begin
      acc <= product;
    end else if (acc_accum) begin
      acc <= result;
    end
  end

endmodule

// File: rtl/complex_mul_seq.sv
// Time-multiplexed complex multiplier: (aR + j aI) * (bR + j bI) computed over
// four cycles with one multiplier and one add/sub accumulator, valid/ready on
// both sides. Defining COMPLEX_MUL_SEQ_CONJ_EN adds the conj_b input, which
// selects A * conj(B) for the operand set accepted alongside it.
module complex_mul_seq
  import complex_mul_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_real,
  input  logic [WIDTH-1:0] a_imag,
  input  logic [WIDTH-1:0] b_real,
  input  logic [WIDTH-1:0] b_imag,
`ifdef COMPLEX_MUL_SEQ_CONJ_EN
  input  logic             conj_b,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_real,
  output logic [WIDTH-1:0] out_imag
);

  state_t           state;
  logic [WIDTH-1:0] a_real_q;
  logic [WIDTH-1:0] a_imag_q;
  logic [WIDTH-1:0] b_real_q;
  logic [WIDTH-1:0] b_imag_q;
  logic             conj_q;

  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             op_sel;
  logic             acc_load;
  logic             acc_accum;
  logic [WIDTH-1:0] mac_result;

`ifdef COMPLEX_MUL_SEQ_CONJ_EN
  // Conjugate request is captured with the operands so it stays fixed per job
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conj_q <= 1'b0;
    end else if (state == IDLE && in_valid && in_ready) begin
      conj_q <= conj_b;
    end
  end
`else
  assign conj_q = 1'b0;
`endif

  // Operand routing and add/sub choice for each multiplier cycle
  always_comb begin
    mul_a     = a_real_q;
    mul_b     = b_real_q;
    op_sel    = OP_SUM;
    acc_load  = 1'b0;
    acc_accum = 1'b0;
    case (state)
      MRR: begin
        acc_load = 1'b1;
      end
      MII: begin
        mul_a     = a_imag_q;
        mul_b     = b_imag_q;
        op_sel    = conj_q ? OP_SUM : OP_SUB;
        acc_accum = 1'b1;
      end
      MIR: begin
        mul_a    = a_imag_q;
        mul_b    = b_real_q;
        acc_load = 1'b1;
      end
      MRI: begin
        mul_b     = b_imag_q;
        op_sel    = conj_q ? OP_SUB : OP_SUM;
        acc_accum = 1'b1;
      end
      default: begin
      end
    endcase
  end

  cmul_mac_unit #(
    .WIDTH(WIDTH)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .op_sel   (op_sel),
    .acc_load (acc_load),
    .acc_accum(acc_accum),
    .result   (mac_result)
  );

  // Sequencer: accept, four multiply cycles, then hold the result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      a_real_q  <= '0;
      a_imag_q  <= '0;
      b_real_q  <= '0;
      b_imag_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_real_q <= a_real;
            a_imag_q <= a_imag;
            b_real_q <= b_real;
            b_imag_q <= b_imag;
            in_ready <= 1'b0;
            state    <= MRR;
          end
        end
        MRR: begin
          state <= MII;
        end
        MII: begin
          out_real <= mac_result;
          state    <= MIR;
        end
        MIR: begin
          state <= MRI;
        end
        MRI: begin
          out_imag  <= mac_result;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_complex_mul_seq.sv
// Self-checking bench for complex_mul_seq (WIDTH=8). Expected results come
// from a plain-integer complex multiply reference; handshake timing is
// checked against the accept/result cycle rules of the block.
module tb_complex_mul_seq;

  localparam int WIDTH = 8;
`ifdef COMPLEX_MUL_SEQ_CONJ_EN
  localparam bit CONJ_BUILD = 1'b1;
`else
  localparam bit CONJ_BUILD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_real;
  logic [WIDTH-1:0] a_imag;
  logic [WIDTH-1:0] b_real;
  logic [WIDTH-1:0] b_imag;
  logic             conj_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_real;
  logic [WIDTH-1:0] out_imag;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  complex_mul_seq #(
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_real   (a_real),
    .a_imag   (a_imag),
    .b_real   (b_real),
    .b_imag   (b_imag),
`ifdef COMPLEX_MUL_SEQ_CONJ_EN
    .conj_b   (conj_b),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_real (out_real),
    .out_imag (out_imag)
  );

  // Reference: full-precision integer complex multiply, truncated to 8 bits
  function automatic logic [15:0] cmulRef(input logic [7:0] ar, input logic [7:0] ai,
                                          input logic [7:0] br, input logic [7:0] bi,
                                          input logic conj);
    int xr, xi, yr, yi, re, im;
    xr = int'(ar);
    xi = int'(ai);
    yr = int'(br);
    yi = int'(bi);
    if (conj && CONJ_BUILD) begin
      re = xr * yr + xi * yi;
      im = xi * yr - xr * yi;
    end else begin
      re = xr * yr - xi * yi;
      im = xi * yr + xr * yi;
    end
    return {im[7:0], re[7:0]};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one operand set for a single cycle; called at a negedge while idle
  task automatic applyStimulus(input logic [7:0] ar, input logic [7:0] ai,
                               input logic [7:0] br, input logic [7:0] bi,
                               input logic conj);
    a_real   = ar;
    a_imag   = ai;
    b_real   = br;
    b_imag   = bi;
    conj_b   = conj;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("accept_in_ready_low", 16'(in_ready), 16'd0);
  endtask

  // Count edges from the accept edge until out_valid, bounded
  task automatic waitResult(input string tag);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 16'(lat), 16'd4);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] exp_r, input logic [7:0] exp_i);
    check({tag, "_real"}, 16'(out_real), 16'(exp_r));
    check({tag, "_imag"}, 16'(out_imag), 16'(exp_i));
    check({tag, "_valid"}, 16'(out_valid), 16'd1);
  endtask

  // Take the result and confirm the block returns to idle with outputs retained
  task automatic handshake(input string tag, input logic [7:0] exp_r, input logic [7:0] exp_i);
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_valid_drop"}, 16'(out_valid), 16'd0);
    check({tag, "_ready_back"}, 16'(in_ready), 16'd1);
    check({tag, "_keep_real"}, 16'(out_real), 16'(exp_r));
    check({tag, "_keep_imag"}, 16'(out_imag), 16'(exp_i));
  endtask

  // Hard time limit so the run always ends
  initial begin
    #300000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0]      exp;
    logic [7:0]       ar, ai, br, bi;
    logic             cj;
    logic [15:0]      expq[$];
    int               acc_cyc[2];
    int               n_acc, n_res, cyc;
    logic [7:0]       set_ops[2][4];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_real    = '0;
    a_imag    = '0;
    b_real    = '0;
    b_imag    = '0;
    conj_b    = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_real", 16'(out_real), 16'd0);
    check("rst_out_imag", 16'(out_imag), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // (3+4j)(2+5j) = -14 + 23j
    applyStimulus(8'd3, 8'd4, 8'd2, 8'd5, 1'b0);
    waitResult("basic");
    checkOutput("basic", 8'hF2, 8'h17);
    handshake("basic", 8'hF2, 8'h17);

    // (100)(3) wraps to 0x2C
    applyStimulus(8'd100, 8'd0, 8'd3, 8'd0, 1'b0);
    waitResult("wrap");
    checkOutput("wrap", 8'h2C, 8'h00);
    handshake("wrap", 8'h2C, 8'h00);

    // Randomized operands against the reference
    for (int k = 0; k < 8; k++) begin
      ar  = 8'($urandom);
      ai  = 8'($urandom);
      br  = 8'($urandom);
      bi  = 8'($urandom);
      cj  = 1'($urandom);
      exp = cmulRef(ar, ai, br, bi, cj);
      applyStimulus(ar, ai, br, bi, cj);
      waitResult("rand");
      checkOutput("rand", exp[7:0], exp[15:8]);
      handshake("rand", exp[7:0], exp[15:8]);
    end

    // Backpressure: result held, stray in_valid ignored
    out_ready = 1'b0;
    exp = cmulRef(8'd10, 8'd20, 8'd30, 8'd40, 1'b0);
    applyStimulus(8'd10, 8'd20, 8'd30, 8'd40, 1'b0);
    waitResult("bp");
    for (int c = 0; c < 10; c++) begin
      check("bp_hold_valid", 16'(out_valid), 16'd1);
      check("bp_hold_in_ready", 16'(in_ready), 16'd0);
      check("bp_hold_real", 16'(out_real), 16'(exp[7:0]));
      check("bp_hold_imag", 16'(out_imag), 16'(exp[15:8]));
      if (c == 3) begin
        a_real   = 8'd99;
        a_imag   = 8'd98;
        b_real   = 8'd97;
        b_imag   = 8'd96;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    handshake("bp", exp[7:0], exp[15:8]);
    exp = cmulRef(8'd7, 8'd250, 8'd9, 8'd13, 1'b0);
    applyStimulus(8'd7, 8'd250, 8'd9, 8'd13, 1'b0);
    waitResult("bp_next");
    checkOutput("bp_next", exp[7:0], exp[15:8]);
    handshake("bp_next", exp[7:0], exp[15:8]);

    // Reset while in MII discards the job
    applyStimulus(8'd5, 8'd6, 8'd7, 8'd8, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 16'(out_valid), 16'd0);
    check("midrst_in_ready", 16'(in_ready), 16'd1);
    check("midrst_out_real", 16'(out_real), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
    waitResult("after_rst");
    checkOutput("after_rst", 8'h00, 8'h02);
    handshake("after_rst", 8'h00, 8'h02);

    // Back-to-back with in_valid held high: one accept every 6 cycles
    set_ops[0] = '{8'd11, 8'd200, 8'd37, 8'd5};
    set_ops[1] = '{8'd129, 8'd64, 8'd255, 8'd2};
    out_ready  = 1'b1;
    n_acc      = 0;
    n_res      = 0;
    cyc        = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    a_real     = set_ops[0][0];
    a_imag     = set_ops[0][1];
    b_real     = set_ops[0][2];
    b_imag     = set_ops[0][3];
    in_valid   = 1'b1;
    while (n_res < 2 && cyc < 40) begin
      if (in_valid && in_ready && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        expq.push_back(cmulRef(a_real, a_imag, b_real, b_imag, 1'b0));
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (expq.size() > 0) begin
          exp = expq.pop_front();
          check("b2b_real", 16'(out_real), 16'(exp[7:0]));
          check("b2b_imag", 16'(out_imag), 16'(exp[15:8]));
        end else begin
          check("b2b_unexpected_result", 16'(out_valid), 16'd0);
        end
        n_res++;
      end
      @(negedge clk);
      cyc++;
      if (n_acc >= 1) begin
        a_real = set_ops[1][0];
        a_imag = set_ops[1][1];
        b_real = set_ops[1][2];
        b_imag = set_ops[1][3];
      end
      if (n_acc >= 2) begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("b2b_results", 16'(n_res), 16'd2);
    check("b2b_accept_spacing", 16'(acc_cyc[1] - acc_cyc[0]), 16'd6);
    @(negedge clk);

`ifdef COMPLEX_MUL_SEQ_CONJ_EN
    // (3+4j) * conj(2+5j) = 26 - 7j
    applyStimulus(8'd3, 8'd4, 8'd2, 8'd5, 1'b1);
    waitResult("conj");
    checkOutput("conj", 8'h1A, 8'hF9);
    handshake("conj", 8'h1A, 8'hF9);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
